// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions used by the sequential multiply-accumulate
// block and the combinational divider that sits beside it.
//   state_t      : controller states of the sequential arithmetic blocks
//   DEF_WIDTH    : default operand width (results are 2*DEF_WIDTH bits)
//   DEF_CNT_W    : bit-counter width for a DEF_WIDTH-step sequential operation
package arith_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_acc_seq.sv
// Sequential unsigned multiply-accumulate: p = a*b + c, one multiplier bit
// per clock, LSB first. Feeding it a divider's (quotient, divisor, remainder)
// rebuilds the dividend.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   a, b, c           multiplicand, multiplier, addend (unsigned, WIDTH bits)
//   out_valid/out_ready result handshake; out_valid held until taken
//   p                 2*WIDTH-bit result, stable in DONE and after handoff
//   busy              high while an operation is in flight (CALC or DONE)
//   state_dbg         current controller state (arith_pkg::state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data until that edge; the consumer
// may drive ready at any time. in_ready and out_valid are never high together.
module mul_acc_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_sum;
  // Multiplicand is pre-shifted each step instead of using a<<cnt, and the
  // multiplier is shifted right so bit 0 is always the current bit b[cnt].
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = CALC;
      CALC:    if (cnt == LAST_CNT)  state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    state_dbg = state;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  // Shift-add datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= {{WIDTH{1'b0}}, c};
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            p <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
